// File: rtl/pc_sequencer.sv
// PC register and fetch/execute sequencer: BOOT -> FETCH -> EXEC loop with HALT/ERROR traps.
// All outputs come from registered state; an instruction takes at least 2 cycles.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] branchPC,
  input  logic [31:0] jmpPC,
  input  logic [31:0] jrTarget,
  input  logic [5:0]  opcode,
  input  logic        stall,
  input  logic        imemReady,
  output logic [31:0] oldPC,
  output logic        imemReq,
  output logic        instrValid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic        halted_q;
  logic        misaligned_q;
  logic [31:0] next_pc_d;

  always_comb begin
    next_pc_d = PCPlus4;
    case (PCSrc)
      2'b00:   next_pc_d = PCPlus4;
      2'b01:   next_pc_d = branchPC;
      2'b10:   next_pc_d = jmpPC;
      default: next_pc_d = jrTarget;
    endcase
  end

  // Flag outputs are registered alongside the state so they never see an input combinationally.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instret_q     <= 32'd0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (imemReady) begin
            state_q       <= EXEC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (stall) begin
            state_q <= EXEC;
          end else if (opcode == HALT_OPCODE) begin
            state_q       <= HALT;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (next_pc_d[1:0] != 2'b00) begin
            state_q       <= ERROR;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            misaligned_q  <= 1'b1;
          end else begin
            state_q       <= FETCH;
            pc_q          <= next_pc_d;
            instret_q     <= instret_q + 32'd1;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
          end
        end
        HALT, ERROR: begin
          state_q <= state_q;
        end
        default: begin
          state_q       <= ERROR;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
          misaligned_q  <= 1'b1;
        end
      endcase
    end
  end

  assign oldPC      = pc_q;
  assign imemReq    = imem_req_q;
  assign instrValid = instr_valid_q;
  assign halted     = halted_q;
  assign misaligned = misaligned_q;
  assign instret    = instret_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and fetch sequencer for the CPU front end, sitting directly upstream and downstream of the PC calculation stage. It holds the current PC and drives it to the PC calculator as `oldPC`. It consumes the candidate next-PC values (PC+4, branch target, jump target, register target) and selects among them under control. It also runs a small fetch/execute state machine with an instruction-memory handshake, stall, halt and misaligned-target trapping, and counts retired instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_OPCODE`, 6'b111111, opcode that stops the sequencer.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `PCSrc` in 2: next-PC select, already resolved by control. 00 = `PCPlus4`, 01 = `branchPC`, 10 = `jmpPC`, 11 = `jrTarget`.
- `PCPlus4` in 32: sequential target from the PC calculator.
- `branchPC` in 32: branch target from the PC calculator.
- `jmpPC` in 32: jump target from the PC calculator.
- `jrTarget` in 32: register-indirect target (rs value).
- `opcode` in 6: instr[31:26] of the instruction currently presented.
- `stall` in 1: hold the current instruction; no PC update.
- `imemReady` in 1: instruction memory has data for `oldPC`.
- `oldPC` out 32: current PC.
- `imemReq` out 1: fetch request for `oldPC`.
- `instrValid` out 1: the instruction at `oldPC` is valid; decode and commit are allowed this cycle.
- `halted` out 1: sequencer stopped (halt or error).
- `misaligned` out 1: a selected target had bits [1:0] ≠ 00.
- `instret` out 32: count of retired instructions.

## Operation
- The block has five states: BOOT, FETCH, EXEC, HALT and ERROR. The state is registered.
- **BOOT**: all outputs are 0 except `oldPC`. The next state is always FETCH.
- **FETCH**: `imemReq`=1.
  - If `imemReady`=1 at the edge, go to EXEC.
  - Otherwise stay in FETCH. `oldPC` holds.
- **EXEC**: `instrValid`=1. Decision priority at the edge, highest first:
  1. `stall`=1: stay in EXEC. PC and `instret` hold.
  2. `opcode`==`HALT_OPCODE`: go to HALT. PC holds. `instret` does not increment, because HALT is not counted.
  3. Selected target has [1:0] ≠ 00: go to ERROR. PC holds. `instret` does not increment.
  4. Otherwise: PC <= selected target, `instret` += 1, go to FETCH.
- **HALT**: `halted`=1; `imemReq`=0 and `instrValid`=0. This state is absorbing; only `Reset` exits it.
- **ERROR**: `halted`=1 and `misaligned`=1; `imemReq`=0 and `instrValid`=0. This state is absorbing; only `Reset` exits it.
- Next-PC selection is a pure 4:1 mux on `PCSrc`. Targets are loaded verbatim, with no arithmetic inside this block.
  - For example, `PCPlus4`=0x0000_0000 arriving from PC 0xFFFF_FFFC is loaded as 0. PC wrap is defined by upstream.
- `instret` wraps from 0xFFFF_FFFF to 0.
- `PCSrc`, the target inputs and `opcode` are ignored outside EXEC.
- `stall` is ignored outside EXEC. A stall asserted during FETCH does not block the handshake.

## Timing
- Reset (asynchronous, `Reset`=0) forces immediately:
  - `oldPC`=`RESET_PC`, state = BOOT;
  - `imemReq`=0, `instrValid`=0, `halted`=0, `misaligned`=0, `instret`=0.
- Reset mid-FETCH or mid-EXEC aborts with no PC update. The sequence after release restarts from BOOT.
- First fetch request: `imemReq` rises on the first edge after `Reset` is released (BOOT lasts 1 cycle).
- Minimum instruction period is 2 cycles: FETCH with `imemReady`=1, then EXEC. Each extra `imemReady`=0 cycle adds 1 cycle.
- Each stall cycle in EXEC adds 1 cycle.
- `oldPC` changes only on the edge that leaves EXEC toward FETCH. It is stable for the entire FETCH+EXEC of one instruction.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- **Reset and sequential**: `RESET_PC`=0, `PCSrc`=00, `PCPlus4`=`oldPC`+4, `imemReady`=1 → `oldPC` steps 0, 4, 8 every 2 cycles; `instret`=3 after 3 EXEC cycles.
- **Branch / jump / jr**: in EXEC at PC 0x10, with `PCSrc`=01 and `branchPC`=0x40 → next FETCH has `oldPC`=0x40. Likewise `PCSrc`=10 with `jmpPC`=0x0040_0000 → `oldPC`=0x0040_0000. Likewise `PCSrc`=11 with `jrTarget`=0x80 → `oldPC`=0x80.
- **Wait and stall**: hold `imemReady`=0 for 3 cycles → `imemReq` stays 1 and `oldPC` is unchanged. Then hold `stall`=1 for 2 EXEC cycles → `instrValid` is high for 3 cycles and the PC advances once.
- **Halt**: `opcode`=6'b111111 in EXEC → `halted`=1 on the next cycle; `imemReq`=0 thereafter; `oldPC` and `instret` are frozen; `PCSrc` changes have no effect.
- **Misaligned**: `PCSrc`=11 with `jrTarget`=0x0000_0006 → ERROR, `misaligned`=1, `halted`=1, `oldPC` keeps its old value. `Reset` pulse → all flags 0 and `oldPC`=`RESET_PC`.
- **Reset mid-fetch and wrap**: assert `Reset` during FETCH → outputs drop to reset values immediately. Separately, preload to `instret`=0xFFFF_FFFF and retire 1 instruction → `instret`=0.
